// File: rtl/ic_axi_pkg.sv
// Shared definitions for the interconnect AXI4-Lite blocks: response codes and
// the SRAM bridge state encoding.
package ic_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WR_HALF   = 3'd1;
    localparam logic [2:0] ST_WR_ACCESS = 3'd2;
    localparam logic [2:0] ST_WR_RSP    = 3'd3;
    localparam logic [2:0] ST_RD_ACCESS = 3'd4;
    localparam logic [2:0] ST_RD_DATA   = 3'd5;
    localparam logic [2:0] ST_RD_RSP    = 3'd6;

endpackage

// File: rtl/ic_addr_range_check.sv
// Combinational window decode: in_range when BASE_ADDR <= addr < BASE_ADDR+SIZE.
// BASE_ADDR must be SIZE-aligned and SIZE a power of two.
module ic_addr_range_check #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned SIZE      = 4096
) (
    input  logic [31:0] addr,
    output logic        in_range
);

    // Mask compare avoids overflow when the window ends at the top of the map.
    localparam logic [31:0] MASK = ~(SIZE - 32'd1);

    assign in_range = ((addr & MASK) == BASE_ADDR);

endmodule

// File: rtl/ic_axi_sram_bridge.sv
// AXI4-Lite slave driving a single-port byte-writable synchronous SRAM.
// One transaction at a time; reads and writes alternate priority under contention.
module ic_axi_sram_bridge
    import ic_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned SIZE      = 4096,
    parameter int unsigned AW        = 10
) (
    input  logic          s0_aclk,
    input  logic          s0_aresetn,
    input  logic          s0_awvalid,
    output logic          s0_awready,
    input  logic [31:0]   s0_awaddr,
    input  logic [2:0]    s0_awprot,
    input  logic          s0_wvalid,
    output logic          s0_wready,
    input  logic [31:0]   s0_wdata,
    input  logic [3:0]    s0_wstrb,
    output logic          s0_bvalid,
    input  logic          s0_bready,
    output logic [1:0]    s0_bresp,
    input  logic          s0_arvalid,
    output logic          s0_arready,
    input  logic [31:0]   s0_araddr,
    input  logic [2:0]    s0_arprot,
    output logic          s0_rvalid,
    input  logic          s0_rready,
    output logic [1:0]    s0_rresp,
    output logic [31:0]   s0_rdata,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic [3:0]    mem_strb,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    logic [2:0]  state_q, state_d;
    logic        prio_rd_q, prio_rd_d;
    logic [31:0] awaddr_q, araddr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_got_q, w_got_q;
    logic [1:0]  bresp_q, rresp_q;
    logic        wr_in_range, rd_in_range;
    logic        rd_win, ar_hs, aw_hs, w_hs;
    logic        unused_prot;

    assign unused_prot = ^{s0_awprot, s0_arprot};

    ic_addr_range_check #(
        .BASE_ADDR(BASE_ADDR),
        .SIZE     (SIZE)
    ) u_wr_range (
        .addr    (awaddr_q),
        .in_range(wr_in_range)
    );

    ic_addr_range_check #(
        .BASE_ADDR(BASE_ADDR),
        .SIZE     (SIZE)
    ) u_rd_range (
        .addr    (araddr_q),
        .in_range(rd_in_range)
    );

    // Readies are qualified by their valid so they read 0 while the bus is idle.
    always_comb begin
        rd_win     = 1'b0;
        s0_arready = 1'b0;
        s0_awready = 1'b0;
        s0_wready  = 1'b0;
        if (state_q == ST_IDLE) begin
            rd_win     = s0_arvalid && (!(s0_awvalid || s0_wvalid) || prio_rd_q);
            s0_arready = rd_win;
            s0_awready = s0_awvalid && !rd_win;
            s0_wready  = s0_wvalid && !rd_win;
        end else if (state_q == ST_WR_HALF) begin
            s0_awready = s0_awvalid && !aw_got_q;
            s0_wready  = s0_wvalid && !w_got_q;
        end
    end

    assign ar_hs = s0_arvalid && s0_arready;
    assign aw_hs = s0_awvalid && s0_awready;
    assign w_hs  = s0_wvalid && s0_wready;

    always_comb begin
        state_d   = state_q;
        prio_rd_d = prio_rd_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_d = ST_RD_ACCESS;
                end else if (aw_hs && w_hs) begin
                    state_d = ST_WR_ACCESS;
                end else if (aw_hs || w_hs) begin
                    state_d = ST_WR_HALF;
                end
            end
            ST_WR_HALF:   if (aw_hs || w_hs) state_d = ST_WR_ACCESS;
            ST_WR_ACCESS: state_d = ST_WR_RSP;
            ST_WR_RSP: begin
                if (s0_bready) begin
                    state_d   = ST_IDLE;
                    prio_rd_d = 1'b1;
                end
            end
            ST_RD_ACCESS: state_d = ST_RD_DATA;
            ST_RD_DATA:   state_d = ST_RD_RSP;
            ST_RD_RSP: begin
                if (s0_rready) begin
                    state_d   = ST_IDLE;
                    prio_rd_d = 1'b0;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s0_aclk or negedge s0_aresetn) begin
        if (!s0_aresetn) begin
            state_q   <= ST_IDLE;
            prio_rd_q <= 1'b1;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_rd_q <= prio_rd_d;
            if (ar_hs) araddr_q <= s0_araddr;
            if (aw_hs) awaddr_q <= s0_awaddr;
            if (w_hs) begin
                wdata_q <= s0_wdata;
                wstrb_q <= s0_wstrb;
            end
            // Remember which half arrived first so WR_HALF only opens the other.
            if (state_q == ST_IDLE) begin
                aw_got_q <= aw_hs;
                w_got_q  <= w_hs;
            end
            if (state_q == ST_WR_ACCESS) begin
                bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (state_q == ST_RD_DATA) begin
                rdata_q <= rd_in_range ? mem_rdata : 32'd0;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign s0_bvalid = (state_q == ST_WR_RSP);
    assign s0_bresp  = bresp_q;
    assign s0_rvalid = (state_q == ST_RD_RSP);
    assign s0_rresp  = rresp_q;
    assign s0_rdata  = rdata_q;

    assign mem_wen   = (state_q == ST_WR_ACCESS) && wr_in_range;
    assign mem_cen   = mem_wen || ((state_q == ST_RD_ACCESS) && rd_in_range);
    assign mem_strb  = mem_wen ? wstrb_q : 4'h0;
    assign mem_addr  = (state_q == ST_WR_ACCESS) ? awaddr_q[AW+1:2] : araddr_q[AW+1:2];
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_ic_axi_sram_bridge.sv
// Scoreboard bench for ic_axi_sram_bridge with a behavioural SRAM model.
module tb_ic_axi_sram_bridge;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        mem_cen, mem_wen;
    logic [3:0]  mem_strb;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int b_cnt = 0;
    int r_cnt = 0;
    int wr_cnt = 0;
    int cen_cnt = 0;
    logic [3:0]  last_strb;
    logic [9:0]  last_addr;
    logic [31:0] mem [0:1023];

    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [1:0]  mon_b;
    logic [33:0] mon_r;
    logic        in_split = 1'b0;
    logic        ar_in_split = 1'b0;

    always #5 clk = ~clk;

    ic_axi_sram_bridge #(
        .BASE_ADDR(32'h0000_0000),
        .SIZE     (4096),
        .AW       (10)
    ) dut (
        .s0_aclk   (clk),
        .s0_aresetn(rst_n),
        .s0_awvalid(awvalid),
        .s0_awready(awready),
        .s0_awaddr (awaddr),
        .s0_awprot (3'b000),
        .s0_wvalid (wvalid),
        .s0_wready (wready),
        .s0_wdata  (wdata),
        .s0_wstrb  (wstrb),
        .s0_bvalid (bvalid),
        .s0_bready (bready),
        .s0_bresp  (bresp),
        .s0_arvalid(arvalid),
        .s0_arready(arready),
        .s0_araddr (araddr),
        .s0_arprot (3'b000),
        .s0_rvalid (rvalid),
        .s0_rready (rready),
        .s0_rresp  (rresp),
        .s0_rdata  (rdata),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_strb  (mem_strb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // SRAM model plus access counters
    always @(posedge clk) begin
        if (mem_cen) begin
            cen_cnt <= cen_cnt + 1;
            if (mem_wen) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_strb[i]) mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
                end
                wr_cnt    <= wr_cnt + 1;
                last_strb <= mem_strb;
                last_addr <= mem_addr;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic fail_msg(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=timeout/unexpected want=event", name);
    endtask

    // Response monitor: pops expectations whenever a handshake is about to occur
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_split && arready) ar_in_split <= 1'b1;
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    fail_msg("unexpected_b");
                end else begin
                    mon_b = exp_b.pop_front();
                    check("bresp", {30'd0, bresp}, {30'd0, mon_b});
                end
                b_cnt++;
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    fail_msg("unexpected_r");
                end else begin
                    mon_r = exp_r.pop_front();
                    check("rresp", {30'd0, rresp}, {30'd0, mon_r[33:32]});
                    check("rdata", rdata, mon_r[31:0]);
                end
                r_cnt++;
            end
        end
    end

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        logic hs = 1'b0;
        awaddr  = a;
        awvalid = 1'b1;
        while (!hs && n < TMO) begin
            @(negedge clk);
            hs = awready;
            n++;
        end
        @(posedge clk);
        #1 awvalid = 1'b0;
        if (!hs) fail_msg("aw_timeout");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        logic hs = 1'b0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        while (!hs && n < TMO) begin
            @(negedge clk);
            hs = wready;
            n++;
        end
        @(posedge clk);
        #1 wvalid = 1'b0;
        if (!hs) fail_msg("w_timeout");
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        logic hs = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        while (!hs && n < TMO) begin
            @(negedge clk);
            hs = arready;
            n++;
        end
        @(posedge clk);
        #1 arvalid = 1'b0;
        if (!hs) fail_msg("ar_timeout");
    endtask

    task automatic wait_b(input int target);
        int n = 0;
        while (b_cnt < target && n < TMO) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (b_cnt < target) fail_msg("b_timeout");
    endtask

    task automatic wait_r(input int target);
        int n = 0;
        while (r_cnt < target && n < TMO) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (r_cnt < target) fail_msg("r_timeout");
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er);
        int tgt = b_cnt + 1;
        exp_b.push_back(er);
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_b(tgt);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed);
        int tgt = r_cnt + 1;
        int lat = 0;
        exp_r.push_back({er, ed});
        send_ar(a);
        while (!rvalid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", lat, 3);
        wait_r(tgt);
    endtask

    initial begin
        int c0, w0, lat;
        int glog [$];
        logic [31:0] rd0;
        logic [1:0]  rr0;
        logic        stable;

        rst_n = 1'b0;
        {awvalid, wvalid, arvalid} = '0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        bready = 1'b1;
        rready = 1'b1;
        #12;
        check("rst_ready", {29'd0, arready, awready, wready}, 32'd0);
        check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_mem", {30'd0, mem_cen, mem_wen}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full write then read-back
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
        check("wr_addr", {22'd0, last_addr}, 32'd4);
        check("wr_strb", {28'd0, last_strb}, 32'hF);
        check("wr_count", wr_cnt, 1);
        axi_read(32'h10, 2'b00, 32'hDEADBEEF);

        // Byte strobe and zero strobe
        axi_write(32'h10, 32'h000000AA, 4'h1, 2'b00);
        check("byte_strb", {28'd0, last_strb}, 32'h1);
        axi_read(32'h10, 2'b00, 32'hDEADBEAA);
        w0 = wr_cnt;
        axi_write(32'h10, 32'hFFFFFFFF, 4'h0, 2'b00);
        check("zero_strb_issued", wr_cnt - w0, 1);
        check("zero_strb_val", {28'd0, last_strb}, 32'h0);
        axi_read(32'h10, 2'b00, 32'hDEADBEAA);

        // Split write with a read pending during WR_HALF
        w0 = wr_cnt;
        exp_b.push_back(2'b00);
        exp_r.push_back({2'b00, 32'h12345678});
        send_aw(32'h20);
        in_split = 1'b1;
        araddr   = 32'h20;
        arvalid  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_w(32'h12345678, 4'hF);
        in_split = 1'b0;
        check("split_arready", {31'd0, ar_in_split}, 32'd0);
        lat = 0;
        while (!arready && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        if (!arready) fail_msg("split_ar_timeout");
        @(posedge clk);
        #1 arvalid = 1'b0;
        wait_b(b_cnt + ((exp_b.size() > 0) ? 1 : 0));
        wait_r(r_cnt + ((exp_r.size() > 0) ? 1 : 0));
        check("split_one_write", wr_cnt - w0, 1);

        // Out-of-range accesses
        c0 = cen_cnt;
        axi_read(32'h2000, 2'b10, 32'h0);
        check("oor_rd_cen", cen_cnt - c0, 0);
        axi_write(32'h2000, 32'h55555555, 4'hF, 2'b10);
        check("oor_wr_cen", cen_cnt - c0, 0);

        // Back-pressure then reset while the read response is held
        rready = 1'b0;
        send_ar(32'h20);
        lat = 0;
        while (!rvalid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        rd0 = rdata;
        rr0 = rresp;
        check("bp_rdata", rd0, 32'h12345678);
        check("bp_rresp", {30'd0, rr0}, 32'd0);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rvalid !== 1'b1 || rdata !== rd0 || rresp !== rr0) stable = 1'b0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_cen", {31'd0, mem_cen}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        rready = 1'b1;
        @(posedge clk);
        #1;

        // Contention straight after reset: read, write, read, write
        exp_r.push_back({2'b00, 32'hDEADBEAA});
        exp_b.push_back(2'b00);
        exp_r.push_back({2'b00, 32'hDEADBEAA});
        exp_b.push_back(2'b00);
        c0 = r_cnt;
        w0 = b_cnt;
        araddr = 32'h10;
        awaddr = 32'h30;
        wdata  = 32'h0BADF00D;
        wstrb  = 4'hF;
        {arvalid, awvalid, wvalid} = 3'b111;
        @(negedge clk);
        check("idle_after_rst", {31'd0, arready}, 32'd1);
        lat = 0;
        while (glog.size() < 4 && lat < TMO) begin
            if (arvalid && arready) glog.push_back(1);
            else if (awvalid && awready && wvalid && wready) glog.push_back(0);
            if (glog.size() < 4) @(negedge clk);
            lat++;
        end
        @(posedge clk);
        #1 {arvalid, awvalid, wvalid} = 3'b000;
        if (glog.size() < 4) begin
            fail_msg("grant_timeout");
        end else begin
            for (int i = 0; i < 4; i++) check($sformatf("grant%0d", i), glog[i], (i % 2 == 0) ? 1 : 0);
        end
        wait_r(c0 + 2);
        wait_b(w0 + 2);

        check("exp_b_empty", exp_b.size(), 0);
        check("exp_r_empty", exp_r.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
